cache_controller: RTL
=====================

CACHE_CONTROLLER -- requirements
Module: cache_controller

Interface
REQ-001 SHALL have parameter WORD, default 32: data word width in bits.
REQ-002 SHALL have parameter ADDRESSL, default 15: word-address width; field split is offset [1:0], index [9:2], tag [ADDRESSL-1:10].
REQ-003 SHALL have parameter MEM_LATENCY, default 4, legal range 1..15: cycles mem_read is held before a block is captured.
REQ-004 SHALL use one clock and a synchronous, active-low reset; ports clk and rstn; all state updates on posedge clk.
REQ-005 clk  input  1  system clock.
REQ-006 rstn  input  1  synchronous active-low reset.
REQ-007 cpu_req  input  1  request valid; held by requester until cpu_ready.
REQ-008 cpu_we  input  1  1 = write, 0 = read.
REQ-009 cpu_addr  input  ADDRESSL  word address.
REQ-010 cpu_wdata  input  WORD  write data.
REQ-011 cpu_rdata  output  WORD  read data, valid while cpu_ready=1 on a read.
REQ-012 cpu_ready  output  1  one-cycle completion pulse.
REQ-013 mem_address  output  ADDRESSL  write address to data memory.
REQ-014 mem_address0..mem_address3  output  ADDRESSL each  block word addresses {tag,index,2'dN}.
REQ-015 mem_read / mem_write  output  1 each  data-memory read enable / write enable.
REQ-016 mem_wdata  output  WORD  data-memory write data.
REQ-017 mem_block0..mem_block3  input  WORD each  block words returned by data memory.

Function
REQ-018 SHALL implement a direct-mapped cache: 256 lines, each 4 words plus tag and valid bit; write-through, no write-allocate.
REQ-019 FSM states SHALL be IDLE, LOOKUP, FILL, WRITE, RESPOND.
REQ-020 IDLE: cpu_req=1 registers cpu_we, cpu_addr and cpu_wdata, then goes to LOOKUP; cpu_req=0 stays in IDLE.
REQ-021 LOOKUP, read hit (valid and tag match): SHALL assert cpu_ready with the cached word and return to IDLE; a read hit completes 2 cycles after the request is accepted.
REQ-022 LOOKUP, read miss: SHALL go to FILL; write (hit or miss): SHALL go to WRITE.
REQ-023 FILL: SHALL hold mem_read=1 and mem_address0..3 stable for exactly MEM_LATENCY cycles.
REQ-024 In the last FILL cycle the block SHALL be captured, the tag written and valid set; the state then goes to RESPOND.
REQ-025 RESPOND: SHALL assert cpu_ready with the requested word from the newly filled line, then go to IDLE.
REQ-026 WRITE: SHALL assert mem_write=1 for one cycle with mem_address=addr and mem_wdata=data.
REQ-027 WRITE on a hit SHALL update the cached word in the same cycle; on a miss the line SHALL be unchanged.
REQ-028 WRITE SHALL assert cpu_ready in the same cycle and return to IDLE.
REQ-029 mem_read SHALL be 0 outside FILL; mem_write SHALL be 0 outside WRITE; never both 1.
REQ-030 Requests are not accepted outside IDLE; cpu_req changes while busy SHALL be ignored.
REQ-031 A held cpu_req on the cycle after cpu_ready SHALL be accepted as a new request.
REQ-032 A conflict miss (same index, different tag) SHALL overwrite the line; there is no dirty state.
REQ-033 cpu_rdata SHALL be 0 when cpu_ready=0.

Reset
REQ-034 rstn=0 SHALL force IDLE and clear all valid bits.
REQ-035 rstn=0 SHALL drive cpu_ready, mem_read and mem_write to 0, and cpu_rdata, mem_wdata and all address outputs to 0.
REQ-036 Reset during FILL or WRITE SHALL abort the operation with no line update, no cpu_ready, and mem_read low from the next cycle.

Configuration
REQ-037 Macro CACHE_STATS_EN defined: SHALL add outputs hit_count and miss_count, 16 bits each, saturating at 16'hFFFF.
REQ-038 With CACHE_STATS_EN: counters SHALL increment once per LOOKUP (reads and writes), SHALL clear on reset, and SHALL NOT wrap.
REQ-039 Without CACHE_STATS_EN: ports and counters SHALL be absent and all other behaviour identical.

Verification
REQ-040 Reset, then read 15'h0040 with memory word 0x40=32'hA5A5_0040 -> mem_read high 4 cycles, mem_address0..3=0x40..0x43; cpu_ready 7 cycles after accept with cpu_rdata=32'hA5A5_0040.
REQ-041 Next, read 15'h0042 -> hit; cpu_ready 2 cycles after accept; mem_read stays 0; data equals memory word 0x42.
REQ-042 Read 15'h0440 (same index, new tag) -> miss and refill; re-read 15'h0040 -> miss again.
REQ-043 Write 32'hDEAD_BEEF to cached 15'h0041 -> mem_write one cycle with mem_address=0x41; a subsequent read of 0x41 hits and returns 32'hDEAD_BEEF.
REQ-044 Write to uncached 15'h1000 -> mem_write pulse; a subsequent read of 15'h1000 misses.
REQ-045 rstn low in cycle 2 of a FILL -> no cpu_ready, mem_read 0 next cycle, previous hits now miss; with CACHE_STATS_EN, counters read 0.

Source files
------------

// File: rtl/cache_controller.sv
// cache_controller: direct-mapped, write-through, no-write-allocate cache (256 lines x 4 words)
// Ports:
//   clk, rstn                  clock, synchronous active-low reset
//   cpu_req/cpu_we/cpu_addr/cpu_wdata  CPU request (held until cpu_ready)
//   cpu_rdata, cpu_ready       read data and one-cycle completion pulse
//   mem_address, mem_wdata, mem_write  write-through port to data memory
//   mem_address0..3, mem_read, mem_block0..3  block fill port from data memory
//   hit_count, miss_count      saturating lookup counters (only with CACHE_STATS_EN)
// Optional feature macro: CACHE_STATS_EN
module cache_controller #(
    parameter int WORD        = 32,
    parameter int ADDRESSL    = 15,
    parameter int MEM_LATENCY = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                cpu_req,
    input  logic                cpu_we,
    input  logic [ADDRESSL-1:0] cpu_addr,
    input  logic [WORD-1:0]     cpu_wdata,
    output logic [WORD-1:0]     cpu_rdata,
    output logic                cpu_ready,
    output logic [ADDRESSL-1:0] mem_address,
    output logic [ADDRESSL-1:0] mem_address0,
    output logic [ADDRESSL-1:0] mem_address1,
    output logic [ADDRESSL-1:0] mem_address2,
    output logic [ADDRESSL-1:0] mem_address3,
    output logic                mem_read,
    output logic                mem_write,
    output logic [WORD-1:0]     mem_wdata,
`ifdef CACHE_STATS_EN
    output logic [15:0]         hit_count,
    output logic [15:0]         miss_count,
`endif
    input  logic [WORD-1:0]     mem_block0,
    input  logic [WORD-1:0]     mem_block1,
    input  logic [WORD-1:0]     mem_block2,
    input  logic [WORD-1:0]     mem_block3
);
    localparam int TAGW = ADDRESSL - 10;
    typedef enum logic [2:0] {IDLE, LOOKUP, FILL, WRITE, RESPOND} state_t;
    state_t                state_q, state_d;
    logic                  we_q;
    logic [ADDRESSL-1:0]   addr_q;
    logic [WORD-1:0]       wdata_q;
    logic                  ready_q, ready_d;
    logic [WORD-1:0]       rdata_q, rdata_d;
    logic [3:0]            cnt_q;
    logic [255:0]          valid_q;
    logic [TAGW-1:0]       tag_q [256];
    logic [WORD-1:0]       data_q [256][4];
    logic [7:0]            idx;
    logic [1:0]            off;
    logic [TAGW-1:0]       tag;
    logic                  hit, last, accept, fill_done;
    logic [WORD-1:0]       word;

    assign idx       = addr_q[9:2];
    assign off       = addr_q[1:0];
    assign tag       = addr_q[ADDRESSL-1:10];
    assign hit       = valid_q[idx] && tag_q[idx] == tag;
    assign word      = data_q[idx][off];
    assign last      = cnt_q == 4'(MEM_LATENCY - 1);
    assign fill_done = state_q == FILL && last;
    // The cycle that shows cpu_ready is already IDLE; blocking acceptance there
    // keeps the still-held request of the finished transaction from re-issuing.
    assign accept    = state_q == IDLE && cpu_req && !ready_q;

    always_comb begin
        state_d = state_q;
        ready_d = 1'b0;
        case (state_q)
            IDLE:    state_d = accept ? LOOKUP : IDLE;
            LOOKUP: begin
                state_d = we_q ? WRITE : (hit ? IDLE : FILL);
                ready_d = we_q || hit;
            end
            FILL:    state_d = last ? RESPOND : FILL;
            WRITE:   state_d = IDLE;
            RESPOND: begin
                state_d = IDLE;
                ready_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase
        rdata_d = (ready_d && !we_q) ? word : '0;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            rdata_q <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            cnt_q   <= state_q == FILL ? cnt_q + 4'd1 : 4'd0;
            if (accept) begin
                we_q    <= cpu_we;
                addr_q  <= cpu_addr;
                wdata_q <= cpu_wdata;
            end
            if (fill_done) valid_q[idx] <= 1'b1;
        end
    end

    // Line storage carries no reset; only the valid bits need clearing.
    always_ff @(posedge clk) begin
        if (rstn) begin
            if (fill_done) begin
                tag_q[idx]     <= tag;
                data_q[idx][0] <= mem_block0;
                data_q[idx][1] <= mem_block1;
                data_q[idx][2] <= mem_block2;
                data_q[idx][3] <= mem_block3;
            end
            if (state_q == WRITE && hit) data_q[idx][off] <= wdata_q;
        end
    end

    // Outputs are gated by rstn so an asserted reset silences them immediately.
    assign cpu_ready    = ready_q && rstn;
    assign cpu_rdata    = cpu_ready ? rdata_q : '0;
    assign mem_read     = rstn && state_q == FILL;
    assign mem_write    = rstn && state_q == WRITE;
    assign mem_address  = mem_write ? addr_q : '0;
    assign mem_wdata    = mem_write ? wdata_q : '0;
    assign mem_address0 = mem_read ? {addr_q[ADDRESSL-1:2], 2'd0} : '0;
    assign mem_address1 = mem_read ? {addr_q[ADDRESSL-1:2], 2'd1} : '0;
    assign mem_address2 = mem_read ? {addr_q[ADDRESSL-1:2], 2'd2} : '0;
    assign mem_address3 = mem_read ? {addr_q[ADDRESSL-1:2], 2'd3} : '0;

`ifdef CACHE_STATS_EN
    logic [15:0] hit_q, miss_q;
    always_ff @(posedge clk) begin
        if (!rstn) begin
            hit_q  <= '0;
            miss_q <= '0;
        end else if (state_q == LOOKUP) begin
            if (hit) hit_q <= hit_q + 16'(hit_q != 16'hFFFF);
            else miss_q <= miss_q + 16'(miss_q != 16'hFFFF);
        end
    end
    assign hit_count  = hit_q;
    assign miss_count = miss_q;
`endif
endmodule
